// File: rtl/cpu_pkg.sv
// Shared CPU definitions: data-processing opcodes, condition codes, execute FSM states.
package cpu_pkg;

  localparam logic [3:0] OPCODE_AND = 4'h0;
  localparam logic [3:0] OPCODE_EOR = 4'h1;
  localparam logic [3:0] OPCODE_SUB = 4'h2;
  localparam logic [3:0] OPCODE_RSB = 4'h3;
  localparam logic [3:0] OPCODE_ADD = 4'h4;
  localparam logic [3:0] OPCODE_ADC = 4'h5;
  localparam logic [3:0] OPCODE_SBC = 4'h6;
  localparam logic [3:0] OPCODE_RSC = 4'h7;
  localparam logic [3:0] OPCODE_TST = 4'h8;
  localparam logic [3:0] OPCODE_TEQ = 4'h9;
  localparam logic [3:0] OPCODE_CMP = 4'hA;
  localparam logic [3:0] OPCODE_CMN = 4'hB;
  localparam logic [3:0] OPCODE_ORR = 4'hC;
  localparam logic [3:0] OPCODE_MOV = 4'hD;
  localparam logic [3:0] OPCODE_BIC = 4'hE;
  localparam logic [3:0] OPCODE_MVN = 4'hF;

  localparam logic [3:0] COND_EQ = 4'h0;
  localparam logic [3:0] COND_NE = 4'h1;
  localparam logic [3:0] COND_CS = 4'h2;
  localparam logic [3:0] COND_CC = 4'h3;
  localparam logic [3:0] COND_MI = 4'h4;
  localparam logic [3:0] COND_PL = 4'h5;
  localparam logic [3:0] COND_VS = 4'h6;
  localparam logic [3:0] COND_VC = 4'h7;
  localparam logic [3:0] COND_HI = 4'h8;
  localparam logic [3:0] COND_LS = 4'h9;
  localparam logic [3:0] COND_GE = 4'hA;
  localparam logic [3:0] COND_LT = 4'hB;
  localparam logic [3:0] COND_GT = 4'hC;
  localparam logic [3:0] COND_LE = 4'hD;
  localparam logic [3:0] COND_AL = 4'hE;
  localparam logic [3:0] COND_NV = 4'hF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_READ = 2'd1,
    ST_EXEC = 2'd2,
    ST_WB   = 2'd3
  } state_e;

  // TST/TEQ/CMP/CMN occupy 8..B: flags only, never a register write
  function automatic logic is_test_op(input logic [3:0] opc);
    return (opc[3:2] == 2'b10);
  endfunction

  function automatic logic is_logical_op(input logic [3:0] opc);
    logic r;
    case (opc)
      OPCODE_AND, OPCODE_EOR, OPCODE_TST, OPCODE_TEQ,
      OPCODE_ORR, OPCODE_MOV, OPCODE_BIC, OPCODE_MVN: r = 1'b1;
      default:                                        r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/cond_check.sv
// ARM condition-field evaluator against NZCV; shared with the branch unit.
module cond_check
  import cpu_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] nzcv,
  output logic       pass
);

  logic n, z, c, v;
  assign {n, z, c, v} = nzcv;

  always_comb begin
    pass = 1'b0;
    case (cond)
      COND_EQ: pass = z;
      COND_NE: pass = !z;
      COND_CS: pass = c;
      COND_CC: pass = !c;
      COND_MI: pass = n;
      COND_PL: pass = !n;
      COND_VS: pass = v;
      COND_VC: pass = !v;
      COND_HI: pass = c && !z;
      COND_LS: pass = !c || z;
      COND_GE: pass = (n == v);
      COND_LT: pass = (n != v);
      COND_GT: pass = !z && (n == v);
      COND_LE: pass = z || (n != v);
      COND_AL: pass = 1'b1;
      COND_NV: pass = 1'b0;
    endcase
  end

endmodule

// File: rtl/dp_exec_ctrl.sv
// Execute sequencer for data-processing instructions: RF read, shared-ALU drive, write-back.
// state | meaning
// IDLE  | ready for a decoded instruction
// READ  | read Rn, evaluate condition; skip retires here
// EXEC  | drive ALU, capture result and NZCV
// WB    | write Rd, commit flags, retire
module dp_exec_ctrl
  import cpu_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      instr_valid,
  output logic                      instr_ready,
  input  logic [3:0]                instr_cond,
  input  logic [3:0]                instr_opcode,
  input  logic                      instr_s,
  input  logic [REG_ADDR_WIDTH-1:0] instr_rn,
  input  logic [REG_ADDR_WIDTH-1:0] instr_rd,
  input  logic [DATA_WIDTH-1:0]     instr_op2,
  output logic [REG_ADDR_WIDTH-1:0] rf_raddr,
  input  logic [DATA_WIDTH-1:0]     rf_rdata,
  output logic                      rf_we,
  output logic [REG_ADDR_WIDTH-1:0] rf_waddr,
  output logic [DATA_WIDTH-1:0]     rf_wdata,
  output logic [3:0]                alu_opcode,
  output logic [DATA_WIDTH-1:0]     alu_operand1,
  output logic [DATA_WIDTH-1:0]     alu_operand2,
  output logic                      alu_carry_in,
  output logic                      alu_flag_en,
  input  logic [DATA_WIDTH-1:0]     alu_result,
  input  logic                      alu_n,
  input  logic                      alu_z,
  input  logic                      alu_c,
  input  logic                      alu_v,
  output logic [3:0]                flags,
  output logic                      done
);

  state_e                      state_q, state_d;
  logic [3:0]                  flags_q, flags_d;
  logic [3:0]                  cond_q, opcode_q;
  logic                        s_q;
  logic [REG_ADDR_WIDTH-1:0]   rd_q, raddr_q;
  logic [DATA_WIDTH-1:0]       op2_q, res_q;
  logic [3:0]                  hflags_q;
  logic [3:0]                  alu_opcode_q;
  logic [DATA_WIDTH-1:0]       alu_op1_q, alu_op2_q;
  logic                        alu_cin_q, alu_fen_q;
  logic                        cond_pass;

  cond_check u_cond (
    .cond (cond_q),
    .nzcv (flags_q),
    .pass (cond_pass)
  );

  always_comb begin
    state_d = state_q;
    flags_d = flags_q;
    case (state_q)
      ST_IDLE: if (instr_valid) state_d = ST_READ;
      ST_READ: state_d = cond_pass ? ST_EXEC : ST_IDLE;
      ST_EXEC: state_d = ST_WB;
      ST_WB: begin
        state_d = ST_IDLE;
        // logical ops leave V alone; their C is the carry-in echoed by the ALU
        if (s_q || is_test_op(opcode_q))
          flags_d = is_logical_op(opcode_q) ? {hflags_q[3:1], flags_q[0]} : hflags_q;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      flags_q      <= 4'b0000;
      cond_q       <= '0;
      opcode_q     <= '0;
      s_q          <= 1'b0;
      rd_q         <= '0;
      raddr_q      <= '0;
      op2_q        <= '0;
      res_q        <= '0;
      hflags_q     <= '0;
      alu_opcode_q <= '0;
      alu_op1_q    <= '0;
      alu_op2_q    <= '0;
      alu_cin_q    <= 1'b0;
      alu_fen_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      flags_q <= flags_d;
      if (state_q == ST_IDLE && instr_valid) begin
        cond_q   <= instr_cond;
        opcode_q <= instr_opcode;
        s_q      <= instr_s;
        rd_q     <= instr_rd;
        raddr_q  <= instr_rn;
        op2_q    <= instr_op2;
      end
      // ALU drive is loaded only for executing instructions and then held
      if (state_q == ST_READ && cond_pass) begin
        alu_opcode_q <= opcode_q;
        alu_op1_q    <= rf_rdata;
        alu_op2_q    <= op2_q;
        alu_cin_q    <= flags_q[1];
        alu_fen_q    <= 1'b1;
      end
      if (state_q == ST_EXEC) begin
        res_q    <= alu_result;
        hflags_q <= {alu_n, alu_z, alu_c, alu_v};
      end
    end
  end

  assign instr_ready  = (state_q == ST_IDLE);
  assign done         = (state_q == ST_WB) || (state_q == ST_READ && !cond_pass);
  assign rf_we        = (state_q == ST_WB) && !is_test_op(opcode_q);
  assign rf_waddr     = (state_q == ST_WB) ? rd_q : '0;
  assign rf_wdata     = (state_q == ST_WB) ? res_q : '0;
  assign rf_raddr     = raddr_q;
  assign alu_opcode   = alu_opcode_q;
  assign alu_operand1 = alu_op1_q;
  assign alu_operand2 = alu_op2_q;
  assign alu_carry_in = alu_cin_q;
  assign alu_flag_en  = alu_fen_q;
  assign flags        = flags_q;

endmodule
